// File: rtl/decode_stage_controller.sv
// rtl/decode_stage_controller.sv - decode stage sequencer: command intake, grow/merge/peel loop, result streaming
module decode_stage_controller #(
  parameter int GRID_WIDTH_X            = 4,
  parameter int GRID_WIDTH_Z            = 1,
  parameter int GRID_WIDTH_U            = 3,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int MAXIMUM_DELAY           = 2,
  parameter int CORRECTION_WIDTH        = 14,
  parameter logic [7:0] START_MSG       = 8'h01,
  parameter logic [7:0] MEAS_HDR        = 8'h02,
  localparam int PU_COUNT = GRID_WIDTH_X * GRID_WIDTH_Z * GRID_WIDTH_U,
  localparam int ALIGNED  = 8 * ((GRID_WIDTH_X * GRID_WIDTH_Z + 7) / 8),
  localparam int CB       = (CORRECTION_WIDTH + 7) / 8,
  localparam int UB       = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  input_data,
  input  logic                        input_valid,
  output logic                        input_ready,
  output logic [7:0]                  output_data,
  output logic                        output_valid,
  input  logic                        output_ready,
  input  logic [PU_COUNT-1:0]         busy_PE,
  input  logic [PU_COUNT-1:0]         odd_clusters_PE,
  output logic [ALIGNED-1:0]          measurements,
  input  logic [CORRECTION_WIDTH-1:0] correction,
  output logic [UB-1:0]               result_round,
  output logic [2:0]                  global_stage,
  output logic [2:0]                  previous_global_stage
);

  localparam int MB  = ALIGNED / 8;
  localparam int RW  = $clog2(GRID_WIDTH_U + 1);
  localparam int DW  = (MAXIMUM_DELAY > 0) ? $clog2(MAXIMUM_DELAY + 1) : 1;
  localparam int ICW = ITERATION_COUNTER_WIDTH;
  localparam logic [DW-1:0] MAXD = DW'(MAXIMUM_DELAY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MEAS_LOAD = 3'd1,
    S_GROW      = 3'd2,
    S_MERGE     = 3'd3,
    S_PEEL      = 3'd4,
    S_RESULT    = 3'd5,
    S_PARAM     = 3'd6,
    S_MEAS_PREP = 3'd7
  } stage_t;

  stage_t r_stage, r_prev, w_next;

  logic [ALIGNED-1:0]          r_meas;
  logic [7:0]                  r_meas_byte;
  logic [RW-1:0]               r_meas_round;
  logic [ICW-1:0]              r_limit;
  logic [ICW-1:0]              r_iter;
  logic                        r_timeout;
  logic [31:0]                 r_cycle;
  logic [DW-1:0]               r_delay;
  logic                        r_busy;
  logic                        r_odd;
  logic                        r_hdr_pending;
  logic [2:0]                  r_hdr_idx;
  logic [7:0]                  r_res_byte;
  logic [UB-1:0]               r_res_round;
  logic                        r_latch;
  logic [CORRECTION_WIDTH-1:0] r_corr;

  logic                        w_in_fire;
  logic                        w_out_fire;
  logic                        w_last_meas_byte;
  logic                        w_last_out;
  logic                        w_delay_done;
  logic                        w_timeout_set;
  logic [RW-1:0]               w_round_inc;
  logic [ICW-1:0]              w_lim_in;
  logic [ALIGNED-1:0]          w_meas_shift;
  logic [CB*8-1:0]             w_corr_pad;
  logic [31:0]                 w_iter32;

  assign w_in_fire        = input_valid && input_ready;
  assign w_out_fire       = output_valid && output_ready;
  assign w_last_meas_byte = (r_meas_byte == 8'(MB - 1));
  assign w_last_out       = !r_hdr_pending && (r_res_byte == 8'(CB - 1)) &&
                            (r_res_round == UB'(GRID_WIDTH_U - 1));
  assign w_delay_done     = (r_delay >= MAXD);
  assign w_round_inc      = r_meas_round + 1'b1;
  assign w_lim_in         = ICW'(input_data);
  assign w_timeout_set    = (r_stage == S_MERGE) && w_delay_done && !r_busy &&
                            r_odd && (r_iter >= r_limit);

  assign measurements          = r_meas;
  assign result_round          = r_res_round;
  assign global_stage          = r_stage;
  assign previous_global_stage = r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= S_IDLE;
      r_prev  <= S_IDLE;
    end else begin
      r_stage <= w_next;
      r_prev  <= r_stage;
    end
  end

  always_comb begin
    w_next       = r_stage;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    output_data  = 8'h00;
    w_meas_shift = r_meas >> 8;
    w_meas_shift[ALIGNED-1 -: 8] = input_data;
    w_corr_pad   = '0;
    w_corr_pad[CORRECTION_WIDTH-1:0] = r_corr;
    w_iter32     = 32'(r_iter);

    input_ready = !reset && ((r_stage == S_IDLE) || (r_stage == S_PARAM) ||
                             (r_stage == S_MEAS_PREP));

    // Correction bytes wait one cycle after a round change so the new round's value can be latched.
    output_valid = (r_stage == S_RESULT) && (r_hdr_pending || !r_latch);
    if (r_hdr_pending) begin
      case (r_hdr_idx)
        3'd0:    output_data = {7'b0, r_timeout};
        3'd1:    output_data = w_iter32[7:0];
        3'd2:    output_data = r_cycle[31:24];
        3'd3:    output_data = r_cycle[23:16];
        3'd4:    output_data = r_cycle[15:8];
        default: output_data = r_cycle[7:0];
      endcase
    end else begin
      output_data = w_corr_pad[{r_res_byte, 3'b000} +: 8];
    end

    case (r_stage)
      S_IDLE: begin
        if (w_in_fire && input_data == START_MSG)     w_next = S_PARAM;
        else if (w_in_fire && input_data == MEAS_HDR) w_next = S_MEAS_PREP;
      end
      S_PARAM:     if (w_in_fire) w_next = S_IDLE;
      S_MEAS_PREP: if (w_in_fire && w_last_meas_byte) w_next = S_MEAS_LOAD;
      S_MEAS_LOAD: w_next = (w_round_inc < RW'(GRID_WIDTH_U)) ? S_MEAS_PREP : S_GROW;
      S_GROW:      w_next = S_MERGE;
      S_MERGE: begin
        if (w_delay_done && !r_busy)
          w_next = (r_odd && (r_iter < r_limit)) ? S_GROW : S_PEEL;
      end
      S_PEEL:      if (w_delay_done && !r_busy) w_next = S_RESULT;
      S_RESULT:    if (w_out_fire && w_last_out) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meas        <= '0;
      r_meas_byte   <= '0;
      r_meas_round  <= '0;
      r_limit       <= '1;
      r_iter        <= '0;
      r_timeout     <= 1'b0;
      r_cycle       <= '0;
      r_delay       <= '0;
      r_busy        <= 1'b0;
      r_odd         <= 1'b0;
      r_hdr_pending <= 1'b0;
      r_hdr_idx     <= '0;
      r_res_byte    <= '0;
      r_res_round   <= '0;
      r_latch       <= 1'b0;
      r_corr        <= '0;
    end else begin
      r_busy <= |busy_PE;
      r_odd  <= |odd_clusters_PE;

      if ((r_stage == S_GROW || r_stage == S_MERGE || r_stage == S_PEEL) && r_cycle != 32'hFFFF_FFFF)
        r_cycle <= r_cycle + 32'd1;

      // Delay restarts on every entry into MERGE or PEELING and saturates at the threshold.
      if ((r_stage == S_MERGE || r_stage == S_PEEL) && w_next == r_stage) begin
        if (!w_delay_done) r_delay <= r_delay + 1'b1;
      end else begin
        r_delay <= '0;
      end

      case (r_stage)
        S_IDLE: begin
          if (w_in_fire && input_data == MEAS_HDR) begin
            r_meas_round <= '0;
            r_meas_byte  <= '0;
          end
        end
        S_PARAM: begin
          if (w_in_fire) r_limit <= (w_lim_in == '0) ? '1 : w_lim_in;
        end
        S_MEAS_PREP: begin
          if (w_in_fire) begin
            r_meas      <= w_meas_shift;
            r_meas_byte <= w_last_meas_byte ? 8'd0 : r_meas_byte + 8'd1;
          end
        end
        S_MEAS_LOAD: begin
          r_meas_round <= w_round_inc;
          r_iter       <= '0;
          r_timeout    <= 1'b0;
          r_cycle      <= 32'd1;
        end
        S_GROW:  r_iter <= r_iter + 1'b1;
        S_MERGE: if (w_timeout_set) r_timeout <= 1'b1;
        S_PEEL: begin
          if (w_next == S_RESULT) begin
            r_hdr_pending <= 1'b1;
            r_hdr_idx     <= '0;
            r_res_byte    <= '0;
            r_res_round   <= '0;
            r_latch       <= 1'b1;
          end
        end
        S_RESULT: begin
          if (r_latch) begin
            r_corr  <= correction;
            r_latch <= 1'b0;
          end
          if (w_out_fire) begin
            if (r_hdr_pending) begin
              if (r_hdr_idx == 3'd5) r_hdr_pending <= 1'b0;
              else                   r_hdr_idx     <= r_hdr_idx + 3'd1;
            end else if (r_res_byte == 8'(CB - 1)) begin
              r_res_byte <= '0;
              if (w_last_out) begin
                r_res_round <= '0;
              end else begin
                r_res_round <= r_res_round + 1'b1;
                r_latch     <= 1'b1;
              end
            end else begin
              r_res_byte <= r_res_byte + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage_controller.sv
// tb/tb_decode_stage_controller.sv - directed self-checking bench for decode_stage_controller
module tb_decode_stage_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  input_data;
  logic        input_valid;
  logic        input_ready;
  logic [7:0]  output_data;
  logic        output_valid;
  logic        output_ready;
  logic [11:0] busy_PE;
  logic [11:0] odd_clusters_PE;
  logic [7:0]  measurements;
  logic [13:0] correction;
  logic [1:0]  result_round;
  logic [2:0]  global_stage;
  logic [2:0]  previous_global_stage;

  int n_cmp  = 0;
  int n_fail = 0;
  int ml_cnt = 0, grow_cnt = 0, merge_cnt = 0, peel_cnt = 0;
  int stab_err = 0;
  int got_n;
  logic [7:0] got [16];
  logic [1:0] rr  [16];
  logic [7:0] exp_basic [12];

  decode_stage_controller dut (
    .clk                   (clk),
    .reset                 (reset),
    .input_data            (input_data),
    .input_valid           (input_valid),
    .input_ready           (input_ready),
    .output_data           (output_data),
    .output_valid          (output_valid),
    .output_ready          (output_ready),
    .busy_PE               (busy_PE),
    .odd_clusters_PE       (odd_clusters_PE),
    .measurements          (measurements),
    .correction            (correction),
    .result_round          (result_round),
    .global_stage          (global_stage),
    .previous_global_stage (previous_global_stage)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (result_round)
      2'd0:    correction = 14'h1234;
      2'd1:    correction = 14'h2ABC;
      2'd2:    correction = 14'h0F0F;
      default: correction = 14'h0000;
    endcase
  end

  always @(negedge clk) begin
    if (global_stage == 3'd1) ml_cnt++;
    if (global_stage == 3'd2) grow_cnt++;
    if (global_stage == 3'd3) merge_cnt++;
    if (global_stage == 3'd4) peel_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    input_data  = b;
    input_valid = 1'b1;
    while (!input_ready && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL send_byte_timeout: input_ready stayed %0b, required 1", input_ready);
    end
    tick();
    input_valid = 1'b0;
  endtask

  task automatic send_meas();
    send_byte(8'h02);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'h0F);
  endtask

  task automatic wait_stage(input logic [2:0] st);
    int c = 0;
    while (global_stage !== st && c < 300) begin
      tick();
      c++;
    end
    n_cmp++;
    if (global_stage !== st) begin
      n_fail++;
      $display("FAIL wait_stage: stage %0d, required %0d", global_stage, st);
    end
  endtask

  task automatic recv(input int n, input int mode);
    int cyc = 0;
    logic [7:0] held = 8'h00;
    logic hv = 1'b0;
    got_n = 0;
    while (got_n < n && cyc < 500) begin
      output_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (hv && output_valid && output_data !== held) stab_err++;
      if (output_valid && output_ready) begin
        got[got_n] = output_data;
        rr[got_n]  = result_round;
        got_n++;
        hv = 1'b0;
      end else if (output_valid) begin
        held = output_data;
        hv   = 1'b1;
      end
      tick();
      cyc++;
    end
    output_ready = 1'b0;
    n_cmp++;
    if (got_n != n) begin
      n_fail++;
      $display("FAIL recv_count: got %0d bytes, required %0d", got_n, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (input_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_input_ready: got %0b, required 0", input_ready);
    end
    tick();
    n_cmp++;
    if (global_stage !== 3'd0 || previous_global_stage !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_stage: got %0d/%0d, required 0/0", global_stage, previous_global_stage);
    end
    n_cmp++;
    if (measurements !== 8'h00 || result_round !== 2'd0 || output_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: meas %h rr %0d ov %0b, required 00 0 0",
               measurements, result_round, output_valid);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (input_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_input_ready: got %0b, required 1", input_ready);
    end
  endtask

  task automatic test_drop();
    send_byte(8'h7F);
    n_cmp++;
    if (global_stage !== 3'd0) begin
      n_fail++;
      $display("FAIL drop_7f: stage %0d, required 0", global_stage);
    end
  endtask

  task automatic test_basic(input string tag);
    int ml0 = ml_cnt, g0 = grow_cnt, m0 = merge_cnt, p0 = peel_cnt;
    send_meas();
    n_cmp++;
    if (global_stage !== 3'd1 || previous_global_stage !== 3'd7 || measurements !== 8'h0F) begin
      n_fail++;
      $display("FAIL %s_last_load: stage %0d prev %0d meas %h, required 1 7 0f",
               tag, global_stage, previous_global_stage, measurements);
    end
    wait_stage(3'd5);
    recv(12, 0);
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (got[i] !== exp_basic[i]) begin
        n_fail++;
        $display("FAIL %s_byte%0d: got %h, required %h", tag, i, got[i], exp_basic[i]);
      end
    end
    n_cmp++;
    if (ml_cnt - ml0 != 3 || grow_cnt - g0 != 1 || merge_cnt - m0 != 3 || peel_cnt - p0 != 3) begin
      n_fail++;
      $display("FAIL %s_stage_visits: ml %0d grow %0d merge %0d peel %0d, required 3 1 3 3",
               tag, ml_cnt - ml0, grow_cnt - g0, merge_cnt - m0, peel_cnt - p0);
    end
    n_cmp++;
    if (global_stage !== 3'd0 || result_round !== 2'd0 || output_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end_idle: stage %0d rr %0d ov %0b, required 0 0 0",
               tag, global_stage, result_round, output_valid);
    end
  endtask

  task automatic test_params();
    int g0;
    send_byte(8'h01);
    send_byte(8'h03);
    n_cmp++;
    if (global_stage !== 3'd0) begin
      n_fail++;
      $display("FAIL param_return_idle: stage %0d, required 0", global_stage);
    end
    odd_clusters_PE = 12'h004;
    g0 = grow_cnt;
    send_meas();
    wait_stage(3'd5);
    recv(12, 0);
    odd_clusters_PE = 12'h000;
    n_cmp++;
    if (grow_cnt - g0 != 3) begin
      n_fail++;
      $display("FAIL param_grow_visits: got %0d, required 3", grow_cnt - g0);
    end
    n_cmp++;
    if (got[0] !== 8'h01 || got[1] !== 8'h03 || got[5] !== 8'h10) begin
      n_fail++;
      $display("FAIL param_header: status %h iter %h cyc %h, required 01 03 10", got[0], got[1], got[5]);
    end
  endtask

  task automatic test_busy();
    int bad = 0;
    send_meas();
    wait_stage(3'd3);
    busy_PE = 12'h800;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (global_stage !== 3'd3) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_hold: left MERGE in %0d cycles, required 0", bad);
    end
    busy_PE = 12'h000;
    tick();
    n_cmp++;
    if (global_stage !== 3'd3) begin
      n_fail++;
      $display("FAIL busy_release_latency: stage %0d, required 3", global_stage);
    end
    tick();
    n_cmp++;
    if (global_stage !== 3'd4 || previous_global_stage !== 3'd3) begin
      n_fail++;
      $display("FAIL busy_release_exit: stage %0d prev %0d, required 4 3", global_stage, previous_global_stage);
    end
    wait_stage(3'd5);
    recv(12, 0);
    n_cmp++;
    if (got[0] !== 8'h00 || got[1] !== 8'h01) begin
      n_fail++;
      $display("FAIL busy_header: status %h iter %h, required 00 01", got[0], got[1]);
    end
    for (int i = 6; i < 12; i++) begin
      n_cmp++;
      if (got[i] !== exp_basic[i]) begin
        n_fail++;
        $display("FAIL busy_corr%0d: got %h, required %h", i, got[i], exp_basic[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int s0 = stab_err;
    send_meas();
    wait_stage(3'd5);
    recv(12, 1);
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (got[i] !== exp_basic[i]) begin
        n_fail++;
        $display("FAIL bp_byte%0d: got %h, required %h", i, got[i], exp_basic[i]);
      end
    end
    n_cmp++;
    if (rr[6] !== 2'd0 || rr[8] !== 2'd1 || rr[10] !== 2'd2) begin
      n_fail++;
      $display("FAIL bp_result_round: got %0d,%0d,%0d, required 0,1,2", rr[6], rr[8], rr[10]);
    end
    n_cmp++;
    if (stab_err != s0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d unstable stalls, required 0", stab_err - s0);
    end
  endtask

  task automatic test_reset_mid();
    send_meas();
    wait_stage(3'd5);
    recv(9, 0);
    n_cmp++;
    if (output_valid !== 1'b1 || output_data !== 8'h2A) begin
      n_fail++;
      $display("FAIL mid_pending: ov %0b data %h, required 1 2a", output_valid, output_data);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (global_stage !== 3'd0 || output_valid !== 1'b0 || result_round !== 2'd0 || measurements !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: stage %0d ov %0b rr %0d meas %h, required 0 0 0 00",
               global_stage, output_valid, result_round, measurements);
    end
    reset = 1'b0;
    tick();
    test_basic("after_reset");
  endtask

  initial begin
    reset           = 1'b1;
    input_data      = 8'h00;
    input_valid     = 1'b0;
    output_ready    = 1'b0;
    busy_PE         = 12'h000;
    odd_clusters_PE = 12'h000;
    exp_basic = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08,
                  8'h34, 8'h12, 8'hBC, 8'h2A, 8'h0F, 8'h0F};
    test_reset();
    test_drop();
    test_basic("basic");
    test_params();
    test_busy();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
